reduce_gate_pipe: RTL and testbench
===================================

# reduce_gate_pipe

Parametrised, pipelined N-input bitwise reduction gate for the Grah-8 custom-component library. It is the successor to the fixed 4-input, 1-bit AND primitive. Channel count, bit width and logic function (AND/OR/XOR and their inversions) are configurable, and each channel can be masked. The reduction tree is registered per level behind a valid/ready handshake, so wide reductions in the ALU flag and condition-decode paths close timing.

## Interface
- UUID, 0, instance identifier, XORed into sub-instance UUIDs
- CHANNELS, 4, number of input operands, ≥1
- BIT_WIDTH, 1, width of each operand, ≥1
- CNT_WIDTH, 16, width of the completed-result counter
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- in_data  input  CHANNELS*BIT_WIDTH  operands; channel k = bits [k*BIT_WIDTH +: BIT_WIDTH]
- in_mask  input  CHANNELS  1 = channel participates, 0 = replaced by identity
- in_mode  input  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 treated as AND
- in_valid  input  1  operand beat offered
- in_ready  output  1  beat accepted when in_valid & in_ready
- out_data  output  BIT_WIDTH  reduction result
- out_all_masked  output  1  every channel of this beat was masked
- out_valid  output  1  result held valid
- out_ready  input  1  consumer accepts when out_valid & out_ready
- result_count  output  CNT_WIDTH  number of results delivered, wraps

## Operation
- LEVELS = max(1, clog2(CHANNELS)); one register stage per tree level.
- Stage 0 captures the masked operands, the mode, and the all-masked flag, then performs the first pairwise combine. Each later stage halves the operand count. An odd leftover operand at any level is paired with the identity.
- Identity: all-ones for the AND/NAND family; all-zeros for the OR/NOR and XOR/XNOR families. Masked channels and padding use the identity.
- The base function (AND, OR or XOR) is applied throughout the tree. Inversion for NAND/NOR/XNOR is applied only to the final level's output.
- All channels masked: out_data = identity, inverted if the mode inverts. out_all_masked = 1.
- CHANNELS = 1: a single registered stage; out_data = operand (or its inverse, or the identity if masked).
- Mode travels with its beat, so a mode change between consecutive beats has no cross-effect.
- result_count increments on each out_valid & out_ready. It wraps from 2^CNT_WIDTH−1 to 0.

## Timing
- Reset (rst=0, asynchronous): all stage valids = 0, out_valid = 0, out_data = 0, out_all_masked = 0, result_count = 0. Data in flight is discarded. in_ready = 1 once the first stage's valid is clear, which is immediately during reset.
- Per-stage ready: ready_k = !valid_k | ready_(k+1), where ready_LEVELS = out_ready. in_ready = ready_0, combinational.
- Latency: a beat accepted at edge t is presented at out_valid after edge t+LEVELS−1, i.e. LEVELS cycles from acceptance to first visibility, with no stalls.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: out_ready = 0 holds out_data, out_valid and out_all_masked stable. Upstream stages keep filling until full; then in_ready = 0. No beat is dropped or duplicated.
- Simultaneous accept and deliver on a full pipeline is allowed; the pipe shifts.
- Inputs are sampled only on acceptance. in_data, in_mask and in_mode are don't-care otherwise.

## Structure
- Package grah_reduce_pkg: mode encoding constants (MODE_AND..MODE_XNOR), the function identity(mode, width), the function is_inverting(mode), and the function base_op(mode, a, b).
- Sub-module reduce_stage (parameters IN_OPS, BIT_WIDTH): one registered tree level with valid/ready, mode and all-masked sideband. It is instantiated LEVELS times via generate.

## Test plan
- CHANNELS=4, BIT_WIDTH=8, mode AND, data {FF,F0,3C,FF}, mask 1111 -> out_data=30, valid 2 cycles after acceptance, result_count=1.
- Same config, mode NOR, data {01,02,04,00}, mask 1011 (channel 2 masked) -> out_data=FC.
- All masked, mode XNOR -> out_data=FF, out_all_masked=1. Then mode XOR with mask 1111 on {AA,55,00,00} -> out_data=FF, out_all_masked=0.
- Back-to-back stream of 10 random beats with out_ready toggling 1,0,0,1,… -> results in order, match the model, and in_ready drops only when all 2 stages are full. result_count=10.
- CHANNELS=5, BIT_WIDTH=1, mode OR, data 10000 (only channel 4 set) -> out_data=1, latency 3. CHANNELS=1, mode NAND, data 1 -> out_data=0, latency 1.
- rst asserted mid-stream with 2 beats in flight -> out_valid=0 and result_count=0 immediately. After release, the first new beat is delivered with nominal latency and no stale data appears.

Source files
------------

// File: rtl/grah_reduce_pkg.sv
// Shared definitions for the Grah-8 reduction gate: mode encoding, per-mode
// identity and base operator, and the operand count at each tree level.
package grah_reduce_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_NOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    // Widest operand the helper functions carry; callers truncate to BIT_WIDTH.
    localparam int OP_W = 256;

    typedef enum logic [1:0] {
        FAM_AND,
        FAM_OR,
        FAM_XOR
    } family_e;

    // Unused encodings 6 and 7 fall back to the AND family.
    function automatic family_e family(input logic [2:0] mode);
        case (mode)
            MODE_OR, MODE_NOR:   return FAM_OR;
            MODE_XOR, MODE_XNOR: return FAM_XOR;
            default:             return FAM_AND;
        endcase
    endfunction

    function automatic logic is_inverting(input logic [2:0] mode);
        return (mode == MODE_NAND) || (mode == MODE_NOR) || (mode == MODE_XNOR);
    endfunction

    function automatic logic [OP_W-1:0] identity(input logic [2:0] mode, input int unsigned width);
        if (family(mode) == FAM_AND) begin
            return {OP_W{1'b1}} >> (OP_W - width);
        end
        return '0;
    endfunction

    function automatic logic [OP_W-1:0] base_op(input logic [2:0] mode,
                                                input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
        case (family(mode))
            FAM_OR:  return a | b;
            FAM_XOR: return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Operands entering tree level `level`: ceil-halved once per preceding level.
    function automatic int level_ops(input int channels, input int level);
        int n;
        n = channels;
        for (int i = 0; i < level; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One registered level of the reduction tree: pairwise combine of IN_OPS
// operands into ceil(IN_OPS/2), with mode and all-masked carried alongside.
module reduce_stage
    import grah_reduce_pkg::*;
#(
    parameter int IN_OPS    = 2,
    parameter int BIT_WIDTH = 1,
    localparam int OUT_OPS  = (IN_OPS + 1) / 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_OPS*BIT_WIDTH-1:0]    in_ops,
    input  logic [2:0]                     in_mode,
    input  logic                           in_all_masked,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [OUT_OPS*BIT_WIDTH-1:0]   out_ops,
    output logic [2:0]                     out_mode,
    output logic                           out_all_masked,
    output logic                           out_valid,
    input  logic                           out_ready
);

    logic [2*OUT_OPS*BIT_WIDTH-1:0] padded;
    logic [OUT_OPS*BIT_WIDTH-1:0]   combined;
    logic [BIT_WIDTH-1:0]           ident;

    // An odd trailing operand is paired with the identity of the beat's mode.
    always_comb begin
        ident    = BIT_WIDTH'(identity(in_mode, BIT_WIDTH));
        padded   = {(2*OUT_OPS){ident}};
        padded[IN_OPS*BIT_WIDTH-1:0] = in_ops;
        combined = '0;
        for (int j = 0; j < OUT_OPS; j++) begin
            combined[j*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(base_op(in_mode,
                OP_W'(padded[(2*j)*BIT_WIDTH +: BIT_WIDTH]),
                OP_W'(padded[(2*j+1)*BIT_WIDTH +: BIT_WIDTH])));
        end
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_ops        <= '0;
            out_mode       <= MODE_AND;
            out_all_masked <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_ops        <= combined;
                out_mode       <= in_mode;
                out_all_masked <= in_all_masked;
            end
        end
    end

endmodule

// File: rtl/reduce_gate_pipe.sv
// Pipelined, maskable N-input bitwise reduction gate (AND/OR/XOR and inversions)
// built from one reduce_stage per tree level behind a valid/ready handshake.
module reduce_gate_pipe
    import grah_reduce_pkg::*;
#(
    parameter int UUID      = 0,
    parameter int CHANNELS  = 4,
    parameter int BIT_WIDTH = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*BIT_WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]           in_mask,
    input  logic [2:0]                    in_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [BIT_WIDTH-1:0]          out_data,
    output logic                          out_all_masked,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_WIDTH-1:0]          result_count
);

    localparam int LEVELS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*BIT_WIDTH-1:0] masked_ops;
    logic [BIT_WIDTH-1:0]          ident;
    logic                          all_masked;

    // Masked channels enter the tree as the identity so they cannot affect the result.
    always_comb begin
        ident      = BIT_WIDTH'(identity(in_mode, BIT_WIDTH));
        masked_ops = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            masked_ops[c*BIT_WIDTH +: BIT_WIDTH] =
                in_mask[c] ? in_data[c*BIT_WIDTH +: BIT_WIDTH] : ident;
        end
    end

    assign all_masked = ~|in_mask;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IN_OPS  = level_ops(CHANNELS, k);
        localparam int OUT_OPS = (IN_OPS + 1) / 2;

        logic [IN_OPS*BIT_WIDTH-1:0]  stg_in_ops;
        logic [2:0]                   stg_in_mode;
        logic                         stg_in_all_masked;
        logic                         stg_in_valid;
        logic                         stg_in_ready;
        logic [OUT_OPS*BIT_WIDTH-1:0] stg_out_ops;
        logic [2:0]                   stg_out_mode;
        logic                         stg_out_all_masked;
        logic                         stg_out_valid;
        logic                         stg_out_ready;

        if (k == 0) begin : g_head
            assign stg_in_ops        = masked_ops;
            assign stg_in_mode       = in_mode;
            assign stg_in_all_masked = all_masked;
            assign stg_in_valid      = in_valid;
            assign in_ready          = stg_in_ready;
        end else begin : g_link
            assign stg_in_ops        = g_lvl[k-1].stg_out_ops;
            assign stg_in_mode       = g_lvl[k-1].stg_out_mode;
            assign stg_in_all_masked = g_lvl[k-1].stg_out_all_masked;
            assign stg_in_valid      = g_lvl[k-1].stg_out_valid;
        end

        // Inversion is applied once, after the last register, using the beat's own mode.
        if (k == LEVELS - 1) begin : g_tail
            assign stg_out_ready  = out_ready;
            assign out_valid      = stg_out_valid;
            assign out_all_masked = stg_out_all_masked;
            assign out_data       = stg_out_ops ^ {BIT_WIDTH{is_inverting(stg_out_mode)}};
        end else begin : g_mid
            assign stg_out_ready = g_lvl[k+1].stg_in_ready;
        end

        reduce_stage #(
            .IN_OPS    (IN_OPS),
            .BIT_WIDTH (BIT_WIDTH)
        ) u_stage (
            .clk            (clk),
            .rst            (rst),
            .in_ops         (stg_in_ops),
            .in_mode        (stg_in_mode),
            .in_all_masked  (stg_in_all_masked),
            .in_valid       (stg_in_valid),
            .in_ready       (stg_in_ready),
            .out_ops        (stg_out_ops),
            .out_mode       (stg_out_mode),
            .out_all_masked (stg_out_all_masked),
            .out_valid      (stg_out_valid),
            .out_ready      (stg_out_ready)
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_count <= '0;
        end else if (out_valid && out_ready) begin
            result_count <= result_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Randomised and directed bench for reduce_gate_pipe: a 4x8 pipe against a
// fold-based reference model, plus 5x1 and 1x1 configurations.
module tb_reduce_gate_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] a_data;  logic [3:0] a_mask;  logic [2:0] a_mode;
    logic a_valid, a_in_ready, a_am, a_ovalid, a_oready;
    logic [7:0]  a_out;   logic [15:0] a_cnt;

    logic [4:0]  b_data;  logic [4:0] b_mask;  logic [2:0] b_mode;
    logic b_valid, b_in_ready, b_am, b_ovalid, b_oready;
    logic [0:0]  b_out;   logic [15:0] b_cnt;

    logic [0:0]  c_data;  logic [0:0] c_mask;  logic [2:0] c_mode;
    logic c_valid, c_in_ready, c_am, c_ovalid, c_oready;
    logic [0:0]  c_out;   logic [15:0] c_cnt;

    reduce_gate_pipe #(.UUID(0), .CHANNELS(4), .BIT_WIDTH(8), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_mask(a_mask), .in_mode(a_mode),
        .in_valid(a_valid), .in_ready(a_in_ready), .out_data(a_out), .out_all_masked(a_am),
        .out_valid(a_ovalid), .out_ready(a_oready), .result_count(a_cnt));

    reduce_gate_pipe #(.UUID(1), .CHANNELS(5), .BIT_WIDTH(1), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_mask(b_mask), .in_mode(b_mode),
        .in_valid(b_valid), .in_ready(b_in_ready), .out_data(b_out), .out_all_masked(b_am),
        .out_valid(b_ovalid), .out_ready(b_oready), .result_count(b_cnt));

    reduce_gate_pipe #(.UUID(2), .CHANNELS(1), .BIT_WIDTH(1), .CNT_WIDTH(16)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_mask(c_mask), .in_mode(c_mode),
        .in_valid(c_valid), .in_ready(c_in_ready), .out_data(c_out), .out_all_masked(c_am),
        .out_valid(c_ovalid), .out_ready(c_oready), .result_count(c_cnt));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: fold every unmasked channel into an identity-seeded accumulator.
    function automatic logic [7:0] ref_reduce(input logic [39:0] data, input logic [7:0] mask,
                                              input logic [2:0] mode, input int ch, input int bw);
        logic [7:0] fm, acc, op;
        int fam;
        fm  = 8'hFF >> (8 - bw);
        fam = (mode == 3'd1 || mode == 3'd4) ? 1 : (mode == 3'd2 || mode == 3'd5) ? 2 : 0;
        acc = (fam == 0) ? fm : 8'h00;
        for (int c = 0; c < ch; c++) begin
            if (mask[c]) begin
                op = 8'((data >> (c * bw))) & fm;
                if (fam == 0)      acc = acc & op;
                else if (fam == 1) acc = acc | op;
                else               acc = acc ^ op;
            end
        end
        if (mode == 3'd3 || mode == 3'd4 || mode == 3'd5) acc = ~acc & fm;
        return acc;
    endfunction

    // Offer one beat to dut_a, then count edges (accept edge = 1) until out_valid.
    task automatic send_a(input logic [31:0] d, input logic [3:0] m, input logic [2:0] md,
                          output int lat);
        check_eq("a_ready_before_send", 64'(a_in_ready), 64'(1));
        a_data = d; a_mask = m; a_mode = md; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; a_data = $urandom; a_mask = 4'($urandom); a_mode = 3'($urandom);
        lat = 1;
        while (!a_ovalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_a(input string tag, input logic [31:0] d, input logic [3:0] m,
                         input logic [2:0] md, input logic [7:0] exp_const);
        int lat;
        send_a(d, m, md, lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'(2));
        check_eq({tag, "_data"}, 64'(a_out), 64'(exp_const));
        check_eq({tag, "_model"}, 64'(a_out), 64'(ref_reduce(40'(d), 8'(m), md, 4, 8)));
        check_eq({tag, "_all_masked"}, 64'(a_am), 64'(m == 4'd0));
        @(posedge clk); #1;
        check_eq({tag, "_drained"}, 64'(a_ovalid), 64'(0));
    endtask

    task automatic run_b(input string tag, input logic [4:0] d, input logic [4:0] m,
                         input logic [2:0] md, input logic exp_const);
        int lat;
        b_data = d; b_mask = m; b_mode = md; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        lat = 1;
        while (!b_ovalid && lat < 20) begin @(posedge clk); #1; lat++; end
        check_eq({tag, "_latency"}, 64'(lat), 64'(3));
        check_eq({tag, "_data"}, 64'(b_out), 64'(exp_const));
        check_eq({tag, "_model"}, 64'(b_out), 64'(ref_reduce(40'(d), 8'(m), md, 5, 1)));
        check_eq({tag, "_all_masked"}, 64'(b_am), 64'(m == 5'd0));
        @(posedge clk); #1;
    endtask

    task automatic run_c(input string tag, input logic d, input logic m,
                         input logic [2:0] md, input logic exp_const);
        int lat;
        c_data = d; c_mask = m; c_mode = md; c_valid = 1'b1;
        @(posedge clk); #1;
        c_valid = 1'b0;
        lat = 1;
        while (!c_ovalid && lat < 20) begin @(posedge clk); #1; lat++; end
        check_eq({tag, "_latency"}, 64'(lat), 64'(1));
        check_eq({tag, "_data"}, 64'(c_out), 64'(exp_const));
        check_eq({tag, "_model"}, 64'(c_out), 64'(ref_reduce(40'(d), 8'(m), md, 1, 1)));
        check_eq({tag, "_all_masked"}, 64'(c_am), 64'(!m));
        @(posedge clk); #1;
    endtask

    logic [7:0] exp_q[$];
    logic       exp_am_q[$];
    logic [7:0] hold_data, exp_d;
    logic       hold, accept, deliver, exp_am;
    int sent, got, occ, cyc, lat;

    initial begin
        rst = 1'b0;
        a_valid = 1'b0; a_oready = 1'b1; a_data = '0; a_mask = '0; a_mode = '0;
        b_valid = 1'b0; b_oready = 1'b1; b_data = '0; b_mask = '0; b_mode = '0;
        c_valid = 1'b0; c_oready = 1'b1; c_data = '0; c_mask = '0; c_mode = '0;
        #1;
        check_eq("rst_in_ready", 64'(a_in_ready), 64'(1));
        check_eq("rst_out_valid", 64'(a_ovalid), 64'(0));
        check_eq("rst_out_data", 64'(a_out), 64'(0));
        check_eq("rst_all_masked", 64'(a_am), 64'(0));
        check_eq("rst_count", 64'(a_cnt), 64'(0));
        check_eq("rst_b_valid", 64'(b_ovalid), 64'(0));
        check_eq("rst_c_valid", 64'(c_ovalid), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        run_a("and4", 32'hFF3CF0FF, 4'b1111, 3'd0, 8'h30);
        check_eq("count_after_and", 64'(a_cnt), 64'(1));
        run_a("nor_masked", 32'h00040201, 4'b1011, 3'd4, 8'hFC);
        run_a("xnor_all_masked", $urandom, 4'b0000, 3'd5, 8'hFF);
        run_a("xor4", 32'h000055AA, 4'b1111, 3'd2, 8'hFF);
        check_eq("count_after_directed", 64'(a_cnt), 64'(4));

        // Fresh pipe for the stalled stream so the count starts from zero.
        #2 rst = 1'b0;
        #1 check_eq("rerst_count", 64'(a_cnt), 64'(0));
        #2 rst = 1'b1;
        @(posedge clk); #1;

        sent = 0; got = 0; occ = 0; cyc = 0; hold = 1'b0; hold_data = '0;
        while (got < 10 && cyc < 300) begin
            a_oready = (cyc % 4 == 0) || (cyc % 4 == 3);
            a_data = $urandom;
            a_mask = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            a_mode = 3'($urandom_range(0, 7));
            a_valid = (sent < 10);
            @(negedge clk);
            check_eq("stream_in_ready", 64'(a_in_ready), 64'((occ < 2) || a_oready));
            if (hold) begin
                check_eq("stall_valid_held", 64'(a_ovalid), 64'(1));
                check_eq("stall_data_held", 64'(a_out), 64'(hold_data));
            end
            deliver = a_ovalid && a_oready;
            accept  = a_valid && a_in_ready;
            hold    = a_ovalid && !a_oready;
            hold_data = a_out;
            if (deliver) begin
                check_eq("stream_expected_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    exp_d  = exp_q.pop_front();
                    exp_am = exp_am_q.pop_front();
                    check_eq("stream_data", 64'(a_out), 64'(exp_d));
                    check_eq("stream_all_masked", 64'(a_am), 64'(exp_am));
                end
                got++;
            end
            if (accept) begin
                exp_q.push_back(ref_reduce(40'(a_data), 8'(a_mask), a_mode, 4, 8));
                exp_am_q.push_back(a_mask == 4'd0);
                sent++;
            end
            occ = occ + int'(accept) - int'(deliver);
            @(posedge clk); #1;
            cyc++;
        end
        a_valid = 1'b0; a_oready = 1'b1;
        check_eq("stream_delivered", 64'(got), 64'(10));
        check_eq("stream_count", 64'(a_cnt), 64'(10));

        // Two beats in flight, stalled, then an asynchronous reset mid-cycle.
        a_oready = 1'b0;
        a_valid = 1'b1; a_data = $urandom; a_mask = 4'hF; a_mode = 3'd1;
        @(posedge clk); #1;
        a_data = $urandom;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check_eq("inflight_valid", 64'(a_ovalid), 64'(1));
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(a_ovalid), 64'(0));
        check_eq("midrst_count", 64'(a_cnt), 64'(0));
        check_eq("midrst_in_ready", 64'(a_in_ready), 64'(1));
        check_eq("midrst_out_data", 64'(a_out), 64'(0));
        #2 rst = 1'b1;
        @(posedge clk); #1;
        a_oready = 1'b1;
        run_a("post_rst", 32'h0F0F0F0F, 4'b0110, 3'd1, 8'h0F);
        check_eq("post_rst_count", 64'(a_cnt), 64'(1));

        run_b("or5_top", 5'b10000, 5'b11111, 3'd1, 1'b1);
        run_b("or5_top_masked", 5'b10000, 5'b01111, 3'd1, 1'b0);
        run_b("and5_all_masked", 5'b00000, 5'b00000, 3'd0, 1'b1);
        check_eq("b_count", 64'(b_cnt), 64'(3));

        run_c("nand1_one", 1'b1, 1'b1, 3'd3, 1'b0);
        run_c("nand1_zero", 1'b0, 1'b1, 3'd3, 1'b1);
        run_c("nand1_masked", 1'b0, 1'b0, 3'd3, 1'b0);
        check_eq("c_count", 64'(c_cnt), 64'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
